// File: rtl/tile_sequencer.sv
// Piano-tiles note sequencer: title screen, random-lane spawn pulses with a speed-scaled pause, final hold.
// Define TILE_NO_REPEAT_EN to stop two consecutive notes landing in the same lane.

module tile_key_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic key_down,
    output logic kill
);
    logic key_q;

    always_ff @(posedge Clk) begin
        if (Reset) key_q <= 1'b0;
        else       key_q <= key_down;
    end

    assign kill = key_down & ~key_q;
endmodule

module tile_sequencer #(
    parameter int LANES      = 4,
    parameter int SONG_LEN   = 20,
    parameter int RAND_W     = 48,
    parameter int PAUSE_BASE = 1000,
    parameter int PAUSE_STEP = 50,
    parameter int PAUSE_MIN  = 100,
    parameter int FINAL_CYC  = 2000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [RAND_W-1:0] randVal,
    input  logic [LANES-1:0]  key_down,
    output logic [LANES-1:0]  spawn,
    output logic [LANES-1:0]  kill,
    output logic              screen,
    output logic              done,
    output logic [3:0]        speed,
    output logic [15:0]       num_notes
);
    localparam int LW    = $clog2(LANES);
    localparam int NSLOT = RAND_W / LW;
`ifdef TILE_NO_REPEAT_EN
    localparam bit NO_REPEAT = 1'b1;
`else
    localparam bit NO_REPEAT = 1'b0;
`endif

    typedef enum logic [2:0] {S_TITLE, S_PICK, S_PAUSE, S_SPAWN, S_CHECK, S_FINAL} state_t;

    state_t          state, state_nx;
    logic [31:0]     pause_cnt, pause_cnt_nx;
    logic [31:0]     plen_q, plen_nx, plen_calc, dec;
    logic [15:0]     num_nx, spd_w, slot;
    logic [LW-1:0]   lane_q, lane_nx, prev_lane, prev_nx;
    logic [LW-1:0]   raw, lane_fix, lane_pick;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_key
            tile_key_edge u_key (
                .Clk      (Clk),
                .Reset    (Reset),
                .key_down (key_down[g]),
                .kill     (kill[g])
            );
        end
    endgenerate

    assign spd_w = 16'd1 + (num_notes >> 1);
    assign speed = (spd_w > 16'd15) ? 4'd15 : spd_w[3:0];

    // Compare before subtracting so a large speed never wraps the pause length.
    assign dec       = (32'(speed) - 32'd1) * 32'(PAUSE_STEP);
    assign plen_calc = (dec >= 32'(PAUSE_BASE) || (32'(PAUSE_BASE) - dec) < 32'(PAUSE_MIN))
                       ? 32'(PAUSE_MIN) : 32'(PAUSE_BASE) - dec;

    assign slot = num_notes % 16'(NSLOT);

    always_comb begin
        raw = '0;
        for (int i = 0; i < NSLOT; i++)
            if (slot == 16'(i)) raw = randVal[i*LW +: LW];
    end

    // A slice can exceed LANES-1 when LANES is not a power of two; fold it back once.
    assign lane_fix  = ({1'b0, raw} >= (LW+1)'(LANES)) ? raw - LW'(LANES) : raw;
    assign lane_pick = (NO_REPEAT && lane_fix == prev_lane && num_notes != 16'd0)
                       ? ((lane_fix == LW'(LANES-1)) ? '0 : lane_fix + 1'b1)
                       : lane_fix;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_TITLE;
            pause_cnt <= '0;
            plen_q    <= '0;
            num_notes <= '0;
            lane_q    <= '0;
            prev_lane <= '0;
        end else begin
            state     <= state_nx;
            pause_cnt <= pause_cnt_nx;
            plen_q    <= plen_nx;
            num_notes <= num_nx;
            lane_q    <= lane_nx;
            prev_lane <= prev_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        pause_cnt_nx = pause_cnt;
        plen_nx      = plen_q;
        num_nx       = num_notes;
        lane_nx      = lane_q;
        prev_nx      = prev_lane;
        spawn        = '0;
        screen       = 1'b0;
        done         = 1'b0;
        case (state)
            S_TITLE: begin
                screen = 1'b1;
                num_nx = '0;
                if (start) state_nx = S_PICK;
            end
            S_PICK: begin
                lane_nx      = lane_pick;
                plen_nx      = plen_calc;
                pause_cnt_nx = '0;
                state_nx     = S_PAUSE;
            end
            S_PAUSE: begin
                pause_cnt_nx = pause_cnt + 32'd1;
                if (pause_cnt == plen_q - 32'd1) state_nx = S_SPAWN;
            end
            S_SPAWN: begin
                spawn    = LANES'(1) << lane_q;
                num_nx   = num_notes + 16'd1;
                prev_nx  = lane_q;
                state_nx = S_CHECK;
            end
            S_CHECK: begin
                if (num_notes >= 16'(SONG_LEN)) begin
                    pause_cnt_nx = '0;
                    state_nx     = S_FINAL;
                end else begin
                    state_nx = S_PICK;
                end
            end
            S_FINAL: begin
                done         = 1'b1;
                pause_cnt_nx = pause_cnt + 32'd1;
                if (pause_cnt == 32'(FINAL_CYC - 1)) state_nx = S_TITLE;
            end
            default: state_nx = S_TITLE;
        endcase
    end
endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer: reset, key edges, reset abort, full songs on three configurations.
module tb_tile_sequencer;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        startA = 1'b0, startBC = 1'b0;
    logic [47:0] randA = 48'h0, randB = '1, randC = 48'h0;
    logic [3:0]  keyA = 4'h0, keyC = 4'h0;
    logic [2:0]  keyB = 3'h0;

    logic [3:0]  spawnA, killA, speedA, spawnC, killC, speedC, speedB;
    logic [2:0]  spawnB, killB;
    logic        screenA, doneA, screenB, doneB, screenC, doneC;
    logic [15:0] numA, numB, numC;

    int cyc = 0;
    int total = 0, pass = 0, fails = 0;
    int tA[$], lA[$], tB[$], lB[$], tC[$];

    tile_sequencer #(.LANES(4), .SONG_LEN(20), .RAND_W(48), .PAUSE_BASE(10), .PAUSE_STEP(1),
                     .PAUSE_MIN(4), .FINAL_CYC(5)) dutA (
        .Clk(Clk), .Reset(Reset), .start(startA), .randVal(randA), .key_down(keyA),
        .spawn(spawnA), .kill(killA), .screen(screenA), .done(doneA), .speed(speedA), .num_notes(numA));

    tile_sequencer #(.LANES(3), .SONG_LEN(30), .RAND_W(48), .PAUSE_BASE(1000), .PAUSE_STEP(50),
                     .PAUSE_MIN(100), .FINAL_CYC(3)) dutB (
        .Clk(Clk), .Reset(Reset), .start(startBC), .randVal(randB), .key_down(keyB),
        .spawn(spawnB), .kill(killB), .screen(screenB), .done(doneB), .speed(speedB), .num_notes(numB));

    tile_sequencer #(.LANES(4), .SONG_LEN(30), .RAND_W(48), .PAUSE_BASE(1000), .PAUSE_STEP(100),
                     .PAUSE_MIN(100), .FINAL_CYC(3)) dutC (
        .Clk(Clk), .Reset(Reset), .start(startBC), .randVal(randC), .key_down(keyC),
        .spawn(spawnC), .kill(killC), .screen(screenC), .done(doneC), .speed(speedC), .num_notes(numC));

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (spawnA != 4'h0) begin tA.push_back(cyc); lA.push_back(int'(spawnA)); end
        if (spawnB != 3'h0) begin tB.push_back(cyc); lB.push_back(int'(spawnB)); end
        if (spawnC != 4'h0) tC.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pause lengths for dutA: max(4, 10 - (speed-1)), speed = 1 + n/2.
    int plenA[20] = '{10,10,9,9,8,8,7,7,6,6,5,5,4,4,4,4,4,4,4,4};
`ifdef TILE_NO_REPEAT_EN
    int laneA[20] = '{1,2,4,8,1,2,1,2,1,2,1,2,1,2,1,2,1,2,1,2};
`else
    int laneA[20] = '{1,2,4,8,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1};
`endif

    initial begin
        int s, base, expt, dcnt, i;

        repeat (3) @(negedge Clk);
        chk("rst_screen", screenA, 1);
        chk("rst_spawn",  spawnA, 0);
        chk("rst_done",   doneA, 0);
        chk("rst_speed",  speedA, 1);
        chk("rst_notes",  numA, 0);
        chk("rst_kill",   killA, 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Key edges, in TITLE
        keyA = 4'b0101;
        #1 chk("kill_rise", killA, 4'b0101);
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            #1 chk("kill_held", killA, 0);
        end
        @(negedge Clk);
        keyA = 4'b1111;
        #1 chk("kill_more", killA, 4'b1010);
        @(negedge Clk);
        keyA = 4'b0000;
        #1 chk("kill_fall", killA, 0);

        // Reset during PAUSE aborts the song
        randA = 48'h0000_0000_00E4;
        @(negedge Clk);
        startA = 1'b1;
        @(negedge Clk);
        startA = 1'b0;
        i = 0;
        while (numA != 16'd1 && i < 50) begin @(negedge Clk); i++; end
        chk("abort_first_note", numA, 1);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("abort_screen", screenA, 1);
        chk("abort_spawn",  spawnA, 0);
        chk("abort_notes",  numA, 0);
        chk("abort_done",   doneA, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Full song on dutA
        base = tA.size();
        startA = 1'b1;
        s = cyc + 1;
        @(negedge Clk);
        startA = 1'b0;
        i = 0;
        while (!doneA && i < 400) begin @(negedge Clk); i++; end
        chk("A_reached_final", doneA, 1);
        chk("A_final_notes", numA, 20);
        chk("A_final_speed", speedA, 11);
        chk("A_count", tA.size() - base, 20);
        if (tA.size() - base == 20) begin
            expt = s + 1 + plenA[0];
            for (int n = 0; n < 20; n++) begin
                if (n > 0) expt = expt + plenA[n] + 3;
                chk($sformatf("A_time%0d", n), tA[base+n], expt);
                chk($sformatf("A_lane%0d", n), lA[base+n], laneA[n]);
            end
            chk("A_done_start", cyc, expt + 2);
        end
        dcnt = 0;
        while (doneA && dcnt < 50) begin @(negedge Clk); dcnt++; end
        chk("A_done_len", dcnt, 5);
        chk("A_back_title", screenA, 1);
        repeat (3) @(negedge Clk);
        chk("A_no_extra", tA.size() - base, 20);

        // dutB (LANES=3, raw slices all 3) and dutC (floor) in parallel
        startBC = 1'b1;
        s = cyc + 1;
        @(negedge Clk);
        startBC = 1'b0;
        i = 0;
        while (!doneB && i < 25000) begin @(negedge Clk); i++; end
        chk("B_reached_final", doneB, 1);
        chk("B_notes", numB, 30);
        chk("B_speed_sat", speedB, 15);
        chk("B_count", tB.size(), 30);
        chk("C_count", tC.size(), 30);
        if (tB.size() == 30 && tC.size() == 30) begin
            chk("B_first", tB[0], s + 1001);
            chk("B_gap1", tB[1] - tB[0], 1003);
            chk("B_gap_speed15", tB[29] - tB[28], 303);
            chk("C_gap1", tC[1] - tC[0], 1003);
            chk("C_gap_floor", tC[29] - tC[28], 103);
            for (int n = 0; n < 30; n++) begin
`ifdef TILE_NO_REPEAT_EN
                chk($sformatf("B_lane%0d", n), lB[n], (n % 2 == 1) ? 2 : 1);
`else
                chk($sformatf("B_lane%0d", n), lB[n], 1);
`endif
            end
        end
        repeat (5) @(negedge Clk);
        chk("B_back_title", screenB, 1);
        chk("C_back_title", screenC, 1);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
